// File: rtl/uart_receiver_with_peripheral.sv
// 8N1 UART receiver that shows each good byte as two hex digits on
// active-low 7-segment outputs ({g,f,e,d,c,b,a} per digit, high nibble on [13:7]).
module uart_receiver_with_peripheral #(
  parameter int CLOCK_COUNTER_WIDTH = 10,
  parameter int BIT_COUNTER_WIDTH   = 3,
  parameter int DATA_WIDTH          = 8,
  parameter int CLOCKS_PER_BIT      = 434
) (
  input  logic        i_clock,
  input  logic        i_resetL,
  input  logic        i_RX,
  output logic [13:0] o_segment_2_digits
);

  localparam logic [CLOCK_COUNTER_WIDTH-1:0] HALF_BIT_LAST =
    CLOCK_COUNTER_WIDTH'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] FULL_BIT_LAST =
    CLOCK_COUNTER_WIDTH'(CLOCKS_PER_BIT - 1);
  localparam logic [BIT_COUNTER_WIDTH-1:0] LAST_BIT_INDEX =
    BIT_COUNTER_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP
  } state_t;

  state_t                         state_reg;
  logic                           rx_meta_reg;
  logic                           rx_sync_reg;
  logic [CLOCK_COUNTER_WIDTH-1:0] clock_count_reg;
  logic [BIT_COUNTER_WIDTH-1:0]   bit_index_reg;
  logic [DATA_WIDTH-1:0]          shift_reg;
  logic [DATA_WIDTH-1:0]          display_reg;

  // Synchronizer resets to 1 so reset release never looks like a start bit.
  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= i_RX;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      state_reg       <= IDLE;
      clock_count_reg <= '0;
      bit_index_reg   <= '0;
      shift_reg       <= '0;
      display_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          clock_count_reg <= '0;
          bit_index_reg   <= '0;
          if (!rx_sync_reg) state_reg <= START;
        end

        START: begin
          if (clock_count_reg == HALF_BIT_LAST) begin
            clock_count_reg <= '0;
            state_reg       <= rx_sync_reg ? IDLE : DATA;
          end else begin
            clock_count_reg <= clock_count_reg + 1'b1;
          end
        end

        DATA: begin
          if (clock_count_reg == FULL_BIT_LAST) begin
            clock_count_reg          <= '0;
            shift_reg[bit_index_reg] <= rx_sync_reg;
            if (bit_index_reg == LAST_BIT_INDEX) begin
              bit_index_reg <= '0;
              state_reg     <= STOP;
            end else begin
              bit_index_reg <= bit_index_reg + 1'b1;
            end
          end else begin
            clock_count_reg <= clock_count_reg + 1'b1;
          end
        end

        STOP: begin
          if (clock_count_reg == FULL_BIT_LAST) begin
            clock_count_reg <= '0;
            // A low stop bit is a framing error: the byte is dropped.
            if (rx_sync_reg) display_reg <= shift_reg;
            state_reg <= CLEANUP;
          end else begin
            clock_count_reg <= clock_count_reg + 1'b1;
          end
        end

        CLEANUP: begin
          clock_count_reg <= '0;
          if (rx_sync_reg) state_reg <= IDLE;
        end

        default: begin
          clock_count_reg <= '0;
          bit_index_reg   <= '0;
          state_reg       <= IDLE;
        end
      endcase
    end
  end

  function automatic logic [6:0] hex_to_segments(input logic [3:0] nibble);
    logic [6:0] pattern;
    case (nibble)
      4'h0: pattern = 7'h40;
      4'h1: pattern = 7'h79;
      4'h2: pattern = 7'h24;
      4'h3: pattern = 7'h30;
      4'h4: pattern = 7'h19;
      4'h5: pattern = 7'h12;
      4'h6: pattern = 7'h02;
      4'h7: pattern = 7'h78;
      4'h8: pattern = 7'h00;
      4'h9: pattern = 7'h10;
      4'hA: pattern = 7'h08;
      4'hB: pattern = 7'h03;
      4'hC: pattern = 7'h46;
      4'hD: pattern = 7'h21;
      4'hE: pattern = 7'h06;
      default: pattern = 7'h0E;
    endcase
    return pattern;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_digit
      assign o_segment_2_digits[gi*7 +: 7] = hex_to_segments(display_reg[gi*4 +: 4]);
    end
  endgenerate

endmodule

// File: tb/tb_uart_receiver_with_peripheral.sv
// Randomized/directed bench for the UART receiver with hex display; a byte-level
// model tracks which byte should be on the display.
module tb_uart_receiver_with_peripheral;

  localparam int CPB = 434;
  localparam logic [13:0] SEG_00 = {7'h40, 7'h40};

  logic        clk;
  logic        resetn;
  logic        rx;
  logic [13:0] seg;

  int error_count = 0;
  int check_count = 0;

  logic [6:0] seg_table [16];
  logic [7:0] shown_byte;

  uart_receiver_with_peripheral #(
    .CLOCK_COUNTER_WIDTH(10),
    .BIT_COUNTER_WIDTH  (3),
    .DATA_WIDTH         (8),
    .CLOCKS_PER_BIT     (CPB)
  ) dut (
    .i_clock           (clk),
    .i_resetL          (resetn),
    .i_RX              (rx),
    .o_segment_2_digits(seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got=%0d required=finished", check_count);
    $fatal(1);
  end

  task automatic check_value(input string tag, input logic [13:0] got, input logic [13:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s: got=%h required=%h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] expected_seg(input logic [7:0] b);
    return {seg_table[b[7:4]], seg_table[b[3:0]]};
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one full 10-bit frame; checks the display just before the stop
  // sample point and again at the end of the stop bit.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int gap);
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      wait_cycles(CPB);
    end
    rx = stop_bit;
    wait_cycles(CPB / 2 - 20);
    check_value("pre_stop", seg, expected_seg(shown_byte));
    wait_cycles(CPB - (CPB / 2 - 20));
    if (stop_bit) shown_byte = data;
    check_value("frame", seg, expected_seg(shown_byte));
    $display("frame data=%h stop=%b seg=%h expected=%h", data, stop_bit, seg, expected_seg(shown_byte));
    rx = 1'b1;
    wait_cycles(gap);
  endtask

  initial begin
    seg_table[0]  = 7'h40; seg_table[1]  = 7'h79; seg_table[2]  = 7'h24; seg_table[3]  = 7'h30;
    seg_table[4]  = 7'h19; seg_table[5]  = 7'h12; seg_table[6]  = 7'h02; seg_table[7]  = 7'h78;
    seg_table[8]  = 7'h00; seg_table[9]  = 7'h10; seg_table[10] = 7'h08; seg_table[11] = 7'h03;
    seg_table[12] = 7'h46; seg_table[13] = 7'h21; seg_table[14] = 7'h06; seg_table[15] = 7'h0E;
    shown_byte = 8'h00;
    resetn = 1'b0;
    rx     = 1'b1;

    // Reset held for two bit times.
    for (int k = 0; k < 9; k++) begin
      wait_cycles(96);
      check_value("reset_hold", seg, SEG_00);
    end
    $display("reset held seg=%h", seg);
    wait_cycles(4);
    resetn = 1'b1;
    wait_cycles(10);
    check_value("after_reset", seg, SEG_00);

    // Single byte, then hold.
    send_frame(8'h61, 1'b1, 0);
    check_value("single_61", seg, {7'h02, 7'h79});
    for (int k = 0; k < 4; k++) begin
      wait_cycles(217);
      check_value("hold_61", seg, expected_seg(shown_byte));
    end

    // Back-to-back frames.
    send_frame(8'hA5, 1'b1, 0);
    check_value("b2b_a5", seg, {7'h08, 7'h12});
    send_frame(8'h3C, 1'b1, 0);
    check_value("b2b_3c", seg, {7'h30, 7'h46});

    // Framing error keeps the previous byte.
    send_frame(8'h61, 1'b1, 0);
    send_frame(8'hFF, 1'b0, 20);
    check_value("framing_err", seg, {7'h02, 7'h79});
    send_frame(8'h0E, 1'b1, 0);
    check_value("after_ferr_0e", seg, {7'h40, 7'h06});

    // Short low glitch must be rejected.
    rx = 1'b0;
    wait_cycles(100);
    rx = 1'b1;
    wait_cycles(600);
    check_value("false_start", seg, expected_seg(shown_byte));
    $display("glitch 100 cycles seg=%h", seg);
    send_frame(8'h61, 1'b1, 0);
    check_value("after_glitch_61", seg, {7'h02, 7'h79});

    // Reset in the middle of data bit 3.
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = 1'b1;
      wait_cycles(CPB);
    end
    rx = 1'b0;
    wait_cycles(CPB / 2);
    resetn = 1'b0;
    #1;
    check_value("reset_mid_frame", seg, SEG_00);
    shown_byte = 8'h00;
    rx = 1'b1;
    wait_cycles(10);
    check_value("reset_mid_hold", seg, SEG_00);
    $display("mid-frame reset seg=%h", seg);
    resetn = 1'b1;
    wait_cycles(10);
    send_frame(8'h9B, 1'b1, 0);
    check_value("after_reset_9b", seg, {7'h10, 7'h03});

    // Random frames; a bad stop bit is followed by enough idle to leave CLEANUP.
    for (int n = 0; n < 5; n++) begin
      logic [7:0] data;
      logic       stop_bit;
      int         gap;
      data     = 8'($urandom_range(0, 255));
      stop_bit = ($urandom_range(0, 3) != 0);
      gap      = stop_bit ? int'($urandom_range(0, 30)) : int'($urandom_range(10, 30));
      send_frame(data, stop_bit, gap);
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
